// File: rtl/lsu_wb.sv
// lsu_wb: load/store unit driving the Wishbone unit request/kill handshake with alignment, steering and timeout
module lsu_wb #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  lsu_valid_i,
  input  logic                  lsu_we_i,
  input  logic [1:0]            lsu_size_i,
  input  logic                  lsu_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [31:0]           lsu_wdata_i,
  input  logic                  lsu_kill_i,
  output logic                  lsu_stall_o,
  output logic                  lsu_done_o,
  output logic [31:0]           lsu_rdata_o,
  output logic                  lsu_misaligned_o,
  output logic                  lsu_bus_err_o,
  output logic                  lsu_timeout_o,
  output logic                  wbm_we_o,
  output logic                  wbm_re_o,
  output logic                  wbm_kill_o,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i,
  output logic [ADDR_WIDTH-1:0] wbs_adr_o,
  output logic [31:0]           wbs_dat_o,
  output logic [3:0]            wbs_sel_o,
  input  logic [31:0]           wbs_dat_i
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] size_q, lane_q;
  logic uns_q, mis, last, end_bus;
  logic [3:0] sel_n;
  logic [31:0] dat_n, rd_n;
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    mis = (lsu_size_i == 2'b11) || (lsu_size_i == 2'b01 && lsu_addr_i[0]) ||
          (lsu_size_i == 2'b10 && lsu_addr_i[1:0] != 2'b00);
    sel_n = lsu_size_i == 2'b00 ? 4'b0001 << lsu_addr_i[1:0] :
            lsu_size_i == 2'b01 ? (lsu_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    dat_n = lsu_size_i == 2'b00 ? {4{lsu_wdata_i[7:0]}} :
            lsu_size_i == 2'b01 ? {2{lsu_wdata_i[15:0]}} : lsu_wdata_i;
    b = wbs_dat_i[{lane_q, 3'b000} +: 8];
    h = lane_q[1] ? wbs_dat_i[31:16] : wbs_dat_i[15:0];
    rd_n = size_q == 2'b00 ? {{24{b[7] & ~uns_q}}, b} :
           size_q == 2'b01 ? {{16{h[15] & ~uns_q}}, h} : wbs_dat_i;
    last = cnt == LAST;
    end_bus = lsu_kill_i || wbm_err_i || wbm_ack_i || last;
  end
  assign wbm_kill_o = state == BUS && (lsu_kill_i || (last && !wbm_ack_i && !wbm_err_i));
  assign lsu_stall_o = (state == IDLE && lsu_valid_i && !lsu_kill_i) || state == BUS;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      size_q <= '0;
      lane_q <= '0;
      uns_q <= 1'b0;
      lsu_done_o <= 1'b0;
      lsu_rdata_o <= '0;
      lsu_misaligned_o <= 1'b0;
      lsu_bus_err_o <= 1'b0;
      lsu_timeout_o <= 1'b0;
      wbm_we_o <= 1'b0;
      wbm_re_o <= 1'b0;
      wbs_adr_o <= '0;
      wbs_dat_o <= '0;
      wbs_sel_o <= '0;
    end else if (state == IDLE) begin
      if (lsu_valid_i && !lsu_kill_i && mis) begin
        lsu_misaligned_o <= 1'b1;
        lsu_done_o <= 1'b1;
        state <= DONE;
      end else if (lsu_valid_i && !lsu_kill_i) begin
        size_q <= lsu_size_i;
        lane_q <= lsu_addr_i[1:0];
        uns_q <= lsu_unsigned_i;
        wbs_adr_o <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
        wbs_dat_o <= dat_n;
        wbs_sel_o <= sel_n;
        wbm_we_o <= lsu_we_i;
        wbm_re_o <= !lsu_we_i;
        cnt <= '0;
        state <= BUS;
      end
    end else if (state == BUS) begin
      if (!end_bus) begin
        cnt <= cnt + 1'b1;
      end else begin
        // we/re drop on the sampling edge so the Wishbone unit never sees a second request
        wbm_we_o <= 1'b0;
        wbm_re_o <= 1'b0;
        state <= lsu_kill_i ? IDLE : DONE;
        lsu_done_o <= !lsu_kill_i;
        lsu_bus_err_o <= !lsu_kill_i && wbm_err_i;
        lsu_timeout_o <= !lsu_kill_i && !wbm_err_i && !wbm_ack_i;
        lsu_rdata_o <= (!lsu_kill_i && !wbm_err_i && wbm_ack_i && !wbm_we_o) ? rd_n : '0;
      end
    end else begin
      lsu_done_o <= 1'b0;
      lsu_rdata_o <= '0;
      lsu_misaligned_o <= 1'b0;
      lsu_bus_err_o <= 1'b0;
      lsu_timeout_o <= 1'b0;
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_lsu_wb.sv
// tb_lsu_wb: directed scoreboard bench for lsu_wb; completions are checked by a decoupled monitor
module tb_lsu_wb;
  logic clk = 0, rst = 1;
  logic valid = 0, we = 0, uns = 0, kill = 0, ack = 0, err = 0;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, wdata = 0, dat_in = 0;
  logic stall, done, mis, berr, tout, wbm_we, wbm_re, wbm_kill;
  logic [31:0] rdata, adr, dat_out;
  logic [3:0] sel;
  int cyc = 0, n_cmp = 0, n_bad = 0, k = 0;
  typedef struct {logic [31:0] rd; logic [2:0] st; int c;} exp_t;
  exp_t q[$];
  exp_t e;

  lsu_wb #(.ADDR_WIDTH(32), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst), .lsu_valid_i(valid), .lsu_we_i(we), .lsu_size_i(size),
    .lsu_unsigned_i(uns), .lsu_addr_i(addr), .lsu_wdata_i(wdata), .lsu_kill_i(kill),
    .lsu_stall_o(stall), .lsu_done_o(done), .lsu_rdata_o(rdata), .lsu_misaligned_o(mis),
    .lsu_bus_err_o(berr), .lsu_timeout_o(tout), .wbm_we_o(wbm_we), .wbm_re_o(wbm_re),
    .wbm_kill_o(wbm_kill), .wbm_ack_i(ack), .wbm_err_i(err), .wbs_adr_o(adr),
    .wbs_dat_o(dat_out), .wbs_sel_o(sel), .wbs_dat_i(dat_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] di);
    valid = 1; we = w; size = s; uns = u; addr = a; wdata = wd; dat_in = di;
    k = cyc;
  endtask

  task automatic push(input logic [31:0] rd, input logic [2:0] st, input int c);
    q.push_back('{rd: rd, st: st, c: c});
  endtask

  task automatic zero_wait;
    tick;
    tick;
    ack = 1;
    tick;
    ack = 0;
    valid = 0;
    tick;
  endtask

  // status packs {misaligned, bus_err, timeout}
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done at cycle %0d: got done=1 expected no completion", cyc);
      end else begin
        e = q.pop_front();
        chk("rdata", rdata, e.rd);
        chk("status", {29'd0, mis, berr, tout}, {29'd0, e.st});
        chk("done_cycle", cyc, e.c);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_re", wbm_re, 0);
    chk("rst_we", wbm_we, 0);
    chk("rst_sel", sel, 0);
    chk("rst_adr", adr, 0);
    tick;
    tick;
    rst = 0;
    tick;
    // signed byte load from lane 3
    req(0, 2'b00, 0, 32'h103, 0, 32'h80FF_1234);
    push(32'hFFFF_FF80, 3'b000, k + 3);
    #1 chk("lb_stall", stall, 1);
    tick;
    chk("lb_re", wbm_re, 1);
    chk("lb_we", wbm_we, 0);
    chk("lb_sel", sel, 4'b1000);
    chk("lb_adr", adr, 32'h100);
    tick;
    ack = 1;
    tick;
    ack = 0;
    valid = 0;
    chk("lb_re_drop", wbm_re, 0);
    tick;
    tick;
    // store half to upper lanes
    req(1, 2'b01, 0, 32'h202, 32'h0000_BEEF, 32'hDEAD_BEEF);
    push(0, 3'b000, k + 3);
    tick;
    chk("sh_we", wbm_we, 1);
    chk("sh_re", wbm_re, 0);
    chk("sh_sel", sel, 4'b1100);
    chk("sh_dat", dat_out, 32'hBEEF_BEEF);
    chk("sh_adr", adr, 32'h200);
    tick;
    chk("sh_we_hold", wbm_we, 1);
    ack = 1;
    tick;
    ack = 0;
    valid = 0;
    chk("sh_we_drop", wbm_we, 0);
    tick;
    tick;
    // misaligned word
    req(0, 2'b10, 0, 32'h006, 0, 0);
    push(0, 3'b100, k + 1);
    tick;
    chk("mis_re", wbm_re, 0);
    chk("mis_stall", stall, 0);
    valid = 0;
    tick;
    tick;
    // slave never responds
    req(0, 2'b10, 0, 32'h010, 0, 32'h55AA_55AA);
    push(0, 3'b001, k + 17);
    for (int i = 1; i <= 16; i++) begin
      tick;
      chk("to_kill", wbm_kill, (i == 16) ? 1 : 0);
    end
    tick;
    valid = 0;
    chk("to_re_drop", wbm_re, 0);
    tick;
    tick;
    // error on first bus cycle of a store
    req(1, 2'b10, 0, 32'h020, 32'h1234_5678, 0);
    push(0, 3'b010, k + 2);
    tick;
    chk("err_dat", dat_out, 32'h1234_5678);
    err = 1;
    tick;
    err = 0;
    valid = 0;
    chk("err_we_drop", wbm_we, 0);
    tick;
    tick;
    // kill coincident with ack: no completion
    req(0, 2'b01, 1, 32'h032, 0, 32'h1234_ABCD);
    tick;
    tick;
    ack = 1;
    kill = 1;
    #1 chk("kill_wbm_kill", wbm_kill, 1);
    tick;
    ack = 0;
    kill = 0;
    valid = 0;
    chk("kill_stall", stall, 0);
    chk("kill_re", wbm_re, 0);
    tick;
    tick;
    tick;
    // reset in the middle of a bus transfer
    req(0, 2'b10, 0, 32'h040, 0, 0);
    tick;
    chk("rb_re", wbm_re, 1);
    #2 rst = 1;
    valid = 0;
    #1;
    chk("rb_stall", stall, 0);
    chk("rb_re0", wbm_re, 0);
    chk("rb_we0", wbm_we, 0);
    chk("rb_done0", done, 0);
    #2 rst = 0;
    tick;
    req(0, 2'b01, 0, 32'h002, 0, 32'h8001_0000);
    push(32'hFFFF_8001, 3'b000, k + 3);
    zero_wait;
    tick;
    req(0, 2'b00, 1, 32'h001, 0, 32'h0000_9A00);
    push(32'h0000_009A, 3'b000, k + 3);
    zero_wait;
    tick;
    req(0, 2'b00, 0, 32'h000, 0, 32'h0000_007F);
    push(32'h0000_007F, 3'b000, k + 3);
    zero_wait;
    tick;
    req(0, 2'b01, 1, 32'h000, 0, 32'h1234_F00D);
    push(32'h0000_F00D, 3'b000, k + 3);
    zero_wait;
    tick;
    req(0, 2'b01, 0, 32'h000, 0, 32'h1234_F00D);
    push(32'hFFFF_F00D, 3'b000, k + 3);
    zero_wait;
    tick;
    // word load with one wait state
    req(0, 2'b10, 0, 32'h044, 0, 32'hCAFE_F00D);
    push(32'hCAFE_F00D, 3'b000, k + 4);
    tick;
    chk("lw_adr", adr, 32'h044);
    chk("lw_sel", sel, 4'b1111);
    tick;
    tick;
    ack = 1;
    tick;
    ack = 0;
    valid = 0;
    tick;
    tick;
    // byte store replicates data across lanes
    req(1, 2'b00, 0, 32'h101, 32'h0000_00A5, 0);
    push(0, 3'b000, k + 3);
    tick;
    chk("sb_sel", sel, 4'b0010);
    chk("sb_dat", dat_out, 32'hA5A5_A5A5);
    tick;
    ack = 1;
    tick;
    ack = 0;
    valid = 0;
    tick;
    tick;
    tick;
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
